// File: rtl/palm_locator.sv
// Streaming palm locator: finds the first horizontal hand run wider than
// MIN_W in a raster binary stream and reports its extents and a palm height.
// Ports: clk, rst (async, active-low); pixel in: pix_valid, pix_sof,
//   object_image; height override: TESTING_SWITCH, palm_height_test;
//   result out: res_valid/res_ready handshake, found, start/end row/col,
//   palm_width, palm_height; frame_drop pulses when an SOF hits a held result.
module palm_locator #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int CW    = 8,
    parameter int MIN_W = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    input  logic          pix_sof,
    input  logic          object_image,
    input  logic          TESTING_SWITCH,
    input  logic [CW-1:0] palm_height_test,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          found,
    output logic [CW-1:0] start_of_palm_r,
    output logic [CW-1:0] start_of_palm_c,
    output logic [CW-1:0] end_of_palm_r,
    output logic [CW-1:0] end_of_palm_c,
    output logic [CW-1:0] palm_width,
    output logic [CW-1:0] palm_height,
    output logic          frame_drop
);

    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_R = CW'(IMG_H - 1);
    localparam logic [CW-1:0] MIN_WC = CW'(MIN_W);

    typedef enum logic [1:0] {ARMED, SCAN, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [CW-1:0] rs_r_q, rs_r_d, rs_c_q, rs_c_d;
    logic          open_q, open_d;
    logic          found_q, found_d, drop_q, drop_d;
    logic [CW-1:0] sr_q, sr_d, sc_q, sc_d, er_q, er_d, ec_q, ec_d;
    logic [CW-1:0] w_q, w_d, h_q, h_d;

    logic          take, cur_open, last_col, last_px, close, qual;
    logic [CW-1:0] cur_r, cur_c, st_r, st_c, end_c, width, height;
    logic [CW:0]   wide;

    always_comb begin
        // SOF always restarts position and drops any partial run
        cur_r    = pix_sof ? '0 : row_q;
        cur_c    = pix_sof ? '0 : col_q;
        cur_open = pix_sof ? 1'b0 : open_q;
        last_col = (cur_c == LAST_C);
        last_px  = last_col && (cur_r == LAST_R);
        st_r     = cur_open ? rs_r_q : cur_r;
        st_c     = cur_open ? rs_c_q : cur_c;
        // object at last col closes inclusively; background closes on col-1
        close    = object_image ? last_col : cur_open;
        end_c    = object_image ? cur_c : cur_c - 1'b1;
        width    = end_c - st_c;
        qual     = close && (width > MIN_WC);
        wide     = {1'b0, width} + {2'b0, width[CW-1:1]};
        height   = wide[CW] ? '1 : wide[CW-1:0];
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rs_r_d  = rs_r_q;
        rs_c_d  = rs_c_q;
        open_d  = open_q;
        found_d = found_q;
        sr_d    = sr_q;
        sc_d    = sc_q;
        er_d    = er_q;
        ec_d    = ec_q;
        w_d     = w_q;
        h_d     = h_q;
        drop_d  = 1'b0;
        take    = 1'b0;

        unique case (state_q)
            ARMED: take = pix_valid & pix_sof;
            SCAN:  take = pix_valid;
            HOLD: begin
                if (res_ready) begin
                    state_d = ARMED;
                    take    = pix_valid & pix_sof;
                end else if (pix_valid && pix_sof) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = ARMED;
        endcase

        if (take) begin
            state_d = SCAN;
            col_d   = last_col ? '0 : cur_c + 1'b1;
            row_d   = last_col ? cur_r + 1'b1 : cur_r;
            open_d  = object_image & ~last_col;
            if (object_image && !cur_open) begin
                rs_r_d = cur_r;
                rs_c_d = cur_c;
            end
            if (qual) begin
                state_d = HOLD;
                found_d = 1'b1;
                sr_d    = st_r;
                sc_d    = st_c;
                er_d    = cur_r;
                ec_d    = end_c;
                w_d     = width;
                h_d     = TESTING_SWITCH ? palm_height_test : height;
            end else if (last_px) begin
                state_d = HOLD;
                found_d = 1'b0;
                sr_d    = '0;
                sc_d    = '0;
                er_d    = '0;
                ec_d    = '0;
                w_d     = '0;
                h_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARMED;
            row_q   <= '0;
            col_q   <= '0;
            rs_r_q  <= '0;
            rs_c_q  <= '0;
            open_q  <= 1'b0;
            found_q <= 1'b0;
            sr_q    <= '0;
            sc_q    <= '0;
            er_q    <= '0;
            ec_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rs_r_q  <= rs_r_d;
            rs_c_q  <= rs_c_d;
            open_q  <= open_d;
            found_q <= found_d;
            sr_q    <= sr_d;
            sc_q    <= sc_d;
            er_q    <= er_d;
            ec_q    <= ec_d;
            w_q     <= w_d;
            h_q     <= h_d;
            drop_q  <= drop_d;
        end
    end

    assign res_valid       = (state_q == HOLD);
    assign found           = found_q;
    assign start_of_palm_r = sr_q;
    assign start_of_palm_c = sc_q;
    assign end_of_palm_r   = er_q;
    assign end_of_palm_c   = ec_q;
    assign palm_width      = w_q;
    assign palm_height     = h_q;
    assign frame_drop      = drop_q;

endmodule

// File: tb/tb_palm_locator.sv
// Directed bench for palm_locator: default-size instance plus a
// 255-wide instance for height saturation.
module tb_palm_locator;

    localparam int W = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pix_valid = 1'b0, pix_sof = 1'b0, object_image = 1'b0;
    logic       ts = 1'b0;
    logic [7:0] pht = 8'd0;
    logic       res_ready = 1'b0;
    logic       res_valid, found, frame_drop;
    logic [7:0] sr, sc, er, ec, pw, ph;

    logic       b_valid = 1'b0, b_sof = 1'b0, b_obj = 1'b0;
    logic       b_res_valid, b_found, b_drop;
    logic [7:0] b_sr, b_sc, b_er, b_ec, b_pw, b_ph;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    palm_locator dut (
        .clk(clk), .rst(rst),
        .pix_valid(pix_valid), .pix_sof(pix_sof),
        .object_image(object_image),
        .TESTING_SWITCH(ts), .palm_height_test(pht),
        .res_valid(res_valid), .res_ready(res_ready),
        .found(found),
        .start_of_palm_r(sr), .start_of_palm_c(sc),
        .end_of_palm_r(er), .end_of_palm_c(ec),
        .palm_width(pw), .palm_height(ph),
        .frame_drop(frame_drop)
    );

    palm_locator #(.IMG_W(255), .IMG_H(2)) dut_b (
        .clk(clk), .rst(rst),
        .pix_valid(b_valid), .pix_sof(b_sof),
        .object_image(b_obj),
        .TESTING_SWITCH(1'b0), .palm_height_test(8'd0),
        .res_valid(b_res_valid), .res_ready(1'b0),
        .found(b_found),
        .start_of_palm_r(b_sr), .start_of_palm_c(b_sc),
        .end_of_palm_r(b_er), .end_of_palm_c(b_ec),
        .palm_width(b_pw), .palm_height(b_ph),
        .frame_drop(b_drop)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic obj_at(input int mode, input int r, input int c);
        case (mode)
            0: return (r == 50) && (c >= 40) && (c <= 70);
            1: return (r % 20 == 5) &&
                      (((c >= 10) && (c <= 27)) || ((c >= 140) && (c <= 157)));
            2: return (r == 10) && (c >= 130);
            default: return 1'b0;
        endcase
    endfunction

    task automatic px(input logic v, input logic s, input logic o);
        @(negedge clk);
        pix_valid    = v;
        pix_sof      = s;
        object_image = o;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int mode, input int r0, input int c0,
                        input int r1, input int c1);
        for (int i = r0 * W + c0; i <= r1 * W + c1; i++) begin
            px(1'b1, (i == 0), obj_at(mode, i / W, i % W));
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic idle();
        px(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #3;
        check("rst_valid", res_valid, 0);
        check("rst_found", found, 0);
        check("rst_width", pw, 0);
        check("rst_height", ph, 0);
        check("rst_drop", frame_drop, 0);
        #19 rst = 1'b1;

        // saturation on a 255-wide instance
        for (int c = 0; c < 255; c++) begin
            @(negedge clk);
            b_valid = 1'b1;
            b_sof   = (c == 0);
            b_obj   = 1'b1;
            @(posedge clk);
            #1;
            if (c == 253) check("b_pre_valid", b_res_valid, 0);
        end
        b_valid = 1'b0;
        check("b_valid", b_res_valid, 1);
        check("b_found", b_found, 1);
        check("b_end_c", b_ec, 254);
        check("b_width", b_pw, 254);
        check("b_height_sat", b_ph, 255);

        // basic run in row 50
        res_ready = 1'b1;
        send(0, 0, 0, 50, 70);
        check("t1_pre_valid", res_valid, 0);
        send(0, 50, 71, 50, 71);
        check("t1_valid", res_valid, 1);
        check("t1_found", found, 1);
        check("t1_start_r", sr, 50);
        check("t1_start_c", sc, 40);
        check("t1_end_r", er, 50);
        check("t1_end_c", ec, 70);
        check("t1_width", pw, 30);
        check("t1_height", ph, 45);
        idle();
        check("t1_valid_drop", res_valid, 0);
        check("t1_width_kept", pw, 30);

        // only width-17 runs: frame ends empty
        send(1, 0, 0, 119, 158);
        check("t2_pre_valid", res_valid, 0);
        send(1, 119, 159, 119, 159);
        check("t2_valid", res_valid, 1);
        check("t2_found", found, 0);
        check("t2_start_r", sr, 0);
        check("t2_start_c", sc, 0);
        check("t2_end_r", er, 0);
        check("t2_end_c", ec, 0);
        check("t2_width", pw, 0);
        check("t2_height", ph, 0);
        idle();

        // run closing on the last column
        send(2, 0, 0, 10, 159);
        check("t3_valid", res_valid, 1);
        check("t3_start_r", sr, 10);
        check("t3_start_c", sc, 130);
        check("t3_end_r", er, 10);
        check("t3_end_c", ec, 159);
        check("t3_width", pw, 29);
        check("t3_height", ph, 43);
        idle();
        ts  = 1'b1;
        pht = 8'd99;
        send(2, 0, 0, 10, 159);
        check("t3_ts_valid", res_valid, 1);
        check("t3_ts_height", ph, 99);
        check("t3_ts_width", pw, 29);
        idle();
        ts  = 1'b0;
        pht = 8'd0;

        // held result, SOFs dropped, then accepted on an SOF
        res_ready = 1'b0;
        send(2, 0, 0, 10, 159);
        check("t5_valid", res_valid, 1);
        px(1'b1, 1'b1, 1'b0);
        check("t5_drop1", frame_drop, 1);
        idle();
        check("t5_drop1_end", frame_drop, 0);
        check("t5_still_valid", res_valid, 1);
        px(1'b1, 1'b1, 1'b1);
        check("t5_drop2", frame_drop, 1);
        idle();
        check("t5_drop2_end", frame_drop, 0);
        check("t5_width_kept", pw, 29);
        check("t5_start_c_kept", sc, 130);
        res_ready = 1'b1;
        px(1'b1, 1'b1, 1'b0);
        check("t5_no_drop", frame_drop, 0);
        check("t5_accepted", res_valid, 0);
        send(2, 0, 1, 10, 159);
        check("t5_new_valid", res_valid, 1);
        check("t5_new_width", pw, 29);
        idle();

        // SOF mid-scan abandons the partial run
        send(2, 0, 0, 10, 140);
        check("t6_partial", res_valid, 0);
        send(2, 0, 0, 10, 159);
        check("t6_restart_valid", res_valid, 1);
        check("t6_restart_start_c", sc, 130);
        check("t6_restart_width", pw, 29);
        check("t6_restart_end_r", er, 10);
        idle();

        // async reset mid-frame
        send(0, 0, 0, 30, 0);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", res_valid, 0);
        check("t6_rst_found", found, 0);
        check("t6_rst_width", pw, 0);
        check("t6_rst_start_c", sc, 0);
        @(negedge clk);
        rst = 1'b1;
        px(1'b1, 1'b0, 1'b1);
        px(1'b1, 1'b0, 1'b1);
        pix_valid = 1'b0;
        check("t6_armed_ignores", res_valid, 0);
        send(0, 0, 0, 50, 71);
        check("t6_fresh_valid", res_valid, 1);
        check("t6_fresh_start_r", sr, 50);
        check("t6_fresh_start_c", sc, 40);
        check("t6_fresh_width", pw, 30);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
